// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration front end: default frame
// width, frame field positions and the receive FSM state type.
package spi_cfg_pkg;

  localparam int FRAME_BITS_DEF = 24;
  localparam int ADDR_MSB       = 19;
  localparam int ADDR_LSB       = 16;
  localparam int DATA_MSB       = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Bundle of SPI pins and frame-delivery outputs of spi_frame_rx.
// slave is the receiver side, master is the host/consumer side.
interface spi_frame_rx_if
  import spi_cfg_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF
) ();

  logic                  i_sck;
  logic                  i_mosi;
  logic                  i_cs_n;
  logic                  o_miso;
  logic [FRAME_BITS-1:0] o_data;
  logic                  o_enable;
  logic                  o_spi_done;
  logic                  o_frame_err;
  logic                  o_busy;

  modport slave (
    input  i_sck, i_mosi, i_cs_n,
    output o_miso, o_data, o_enable, o_spi_done, o_frame_err, o_busy
  );

  modport master (
    output i_sck, i_mosi, i_cs_n,
    input  o_miso, o_data, o_enable, o_spi_done, o_frame_err, o_busy
  );

endinterface

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, followed by
// rise/fall detection against a registered copy of the last stage.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] syncChain_q;
  logic              prev_q;

  // Shift the pin through the chain and remember the previous settled value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      syncChain_q <= {STAGES{RESET_VAL}};
      prev_q      <= RESET_VAL;
    end else begin
      syncChain_q <= {syncChain_q[STAGES-2:0], i_async};
      prev_q      <= syncChain_q[STAGES-1];
    end
  end

  assign o_level = syncChain_q[STAGES-1];
  assign o_rise  = ~prev_q &  syncChain_q[STAGES-1];
  assign o_fall  =  prev_q & ~syncChain_q[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave frame receiver, oversampled on i_clk. Accepts only
// frames of exactly FRAME_BITS bits, presents them with a stretched write
// strobe, and flags malformed frames.
// Optional: define SPI_MISO_ECHO_EN to echo the previous accepted frame on
// o_miso during the next frame (otherwise o_miso is tied low).
module spi_frame_rx
  import spi_cfg_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int EN_HOLD     = 4
) (
  input logic            i_clk,
  input logic            i_rst_n,
  spi_frame_rx_if.slave  bus
);

  localparam int CNT_W  = $clog2(FRAME_BITS + 2);
  localparam int HOLD_W = $clog2(EN_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_BITS + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(EN_HOLD);

  logic sckLevel, sckRise, sckFall;
  logic mosiLevel, mosiRise, mosiFall;
  logic csLevel, csRise, csFall;

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  accept;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncSck (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(bus.i_sck),
    .o_level(sckLevel), .o_rise(sckRise), .o_fall(sckFall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncMosi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(bus.i_mosi),
    .o_level(mosiLevel), .o_rise(mosiRise), .o_fall(mosiFall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSyncCs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(bus.i_cs_n),
    .o_level(csLevel), .o_rise(csRise), .o_fall(csFall)
  );

  logic unusedSyncBits;
  assign unusedSyncBits = ^{sckLevel, sckFall, mosiRise, mosiFall};

  assign accept = (state_q == CHECK) && (bitCnt_q == CNT_FULL);

  // Next-state logic: frame FSM, bit capture, accept/reject and strobe timer.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    err_d    = err_q;
    hold_d   = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
    case (state_q)
      IDLE: begin
        if (csFall) begin
          state_d  = SHIFT;
          bitCnt_d = '0;
        end
      end
      SHIFT: begin
        if (sckRise) begin
          if (bitCnt_q < CNT_FULL) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], mosiLevel};
          end
          if (bitCnt_q != CNT_SAT) begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
        if (csRise) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          data_d = shreg_q;
          err_d  = 1'b0;
          hold_d = HOLD_INIT;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any partially received frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_frame_err = err_q;
  assign bus.o_enable    = (hold_q != '0);
  assign bus.o_spi_done  = (hold_q == HOLD_W'(1));
  assign bus.o_busy      = ~csLevel;

`ifdef SPI_MISO_ECHO_EN
  logic [FRAME_BITS-1:0] tx_q;

  // Echo register: reload with each accepted frame, shift out on SCK falls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_q <= '0;
    end else if (accept) begin
      tx_q <= shreg_q;
    end else if (!csLevel && sckFall) begin
      tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign bus.o_miso = ~csLevel & tx_q[FRAME_BITS-1];
`else
  assign bus.o_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed, table-driven bench for spi_frame_rx. SCK runs at f_clk/8.
// Covers valid frames, short/long/empty frames, back-to-back frames,
// mid-frame reset, stray SCK with CS high, and the MISO echo when
// SPI_MISO_ECHO_EN is defined.
module tb_spi_frame_rx;

  localparam int EN_HOLD = 4;

  typedef struct {
    int          nBits;
    logic [31:0] value;
    bit          expAccept;
    logic [31:0] expData;
    bit          expErr;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          len;
    int          doneAt;
  } burst_t;

  logic   clock;
  logic   resetN;
  int     checks;
  int     errors;
  burst_t bursts[$];
  bit     inBurst;
  burst_t curBurst;
  vec_t   vecs[6];
  logic [31:0] misoBits;

  spi_frame_rx_if #(.FRAME_BITS(24)) bus ();

  spi_frame_rx #(.FRAME_BITS(24), .SYNC_STAGES(2), .EN_HOLD(EN_HOLD)) dut (
    .i_clk  (clock),
    .i_rst_n(resetN),
    .bus    (bus)
  );

  // Free-running system clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Record every o_enable burst: its length, where o_spi_done fired and the data.
  always @(negedge clock) begin
    if (bus.o_enable) begin
      if (!inBurst) begin
        inBurst         = 1'b1;
        curBurst.len    = 0;
        curBurst.doneAt = -1;
      end
      curBurst.len = curBurst.len + 1;
      if (bus.o_spi_done) curBurst.doneAt = curBurst.len;
      curBurst.data = 32'(bus.o_data);
    end else if (inBurst) begin
      inBurst = 1'b0;
      bursts.push_back(curBurst);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one SPI frame, MSB first; MISO is sampled just before each SCK rise.
  task automatic applyStimulus(input int nBits, input logic [31:0] value,
                               input bit raiseCs, output logic [31:0] miso);
    miso = '0;
    bus.i_cs_n = 1'b0;
    repeat (4) tick();
    for (int i = nBits - 1; i >= 0; i--) begin
      bus.i_mosi = value[i];
      repeat (4) tick();
      miso = {miso[30:0], bus.o_miso};
      bus.i_sck = 1'b1;
      repeat (4) tick();
      bus.i_sck = 1'b0;
    end
    repeat (4) tick();
    if (raiseCs) bus.i_cs_n = 1'b1;
  endtask

  // Let the frame settle, then compare strobe bursts and outputs.
  task automatic checkOutput(input string name, input bit expAccept,
                             input logic [31:0] expData, input bit expErr);
    repeat (20) @(negedge clock);
    checkValue({name, " burst count"}, 32'(bursts.size()), expAccept ? 32'd1 : 32'd0);
    if (expAccept && bursts.size() > 0) begin
      checkValue({name, " enable length"}, 32'(bursts[0].len), 32'(EN_HOLD));
      checkValue({name, " done position"}, 32'(bursts[0].doneAt), 32'(EN_HOLD));
      checkValue({name, " burst data"}, bursts[0].data, expData);
    end
    checkValue({name, " o_data"}, 32'(bus.o_data), expData);
    checkValue({name, " o_frame_err"}, 32'(bus.o_frame_err), 32'(expErr));
    checkValue({name, " o_busy"}, 32'(bus.o_busy), 32'd0);
    bursts.delete();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    inBurst = 1'b0;

    vecs[0] = '{24, 32'h031234,   1'b1, 32'h031234, 1'b0, "frame 031234"};
    vecs[1] = '{23, 32'h2AAAAA,   1'b0, 32'h031234, 1'b1, "23-bit frame"};
    vecs[2] = '{25, 32'h1555555,  1'b0, 32'h031234, 1'b1, "25-bit frame"};
    vecs[3] = '{24, 32'h0B0005,   1'b1, 32'h0B0005, 1'b0, "frame 0B0005"};
    vecs[4] = '{0,  32'h0,        1'b0, 32'h0B0005, 1'b1, "zero-bit frame"};
    vecs[5] = '{24, 32'h0F8001,   1'b1, 32'h0F8001, 1'b0, "frame 0F8001"};

    resetN     = 1'b0;
    bus.i_cs_n = 1'b1;
    bus.i_sck  = 1'b0;
    bus.i_mosi = 1'b0;
    repeat (3) tick();
    checkValue("reset o_data", 32'(bus.o_data), 32'd0);
    checkValue("reset o_enable", 32'(bus.o_enable), 32'd0);
    checkValue("reset o_spi_done", 32'(bus.o_spi_done), 32'd0);
    checkValue("reset o_frame_err", 32'(bus.o_frame_err), 32'd0);
    checkValue("reset o_busy", 32'(bus.o_busy), 32'd0);
    checkValue("reset o_miso", 32'(bus.o_miso), 32'd0);
    resetN = 1'b1;
    repeat (5) tick();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].nBits, vecs[v].value, 1'b1, misoBits);
      checkOutput(vecs[v].name, vecs[v].expAccept, vecs[v].expData, vecs[v].expErr);
    end

    // Back-to-back frames with only two cycles of CS high between them.
    applyStimulus(24, 32'h010F00, 1'b1, misoBits);
    repeat (2) tick();
    applyStimulus(24, 32'h0400AA, 1'b1, misoBits);
    repeat (20) @(negedge clock);
    checkValue("b2b burst count", 32'(bursts.size()), 32'd2);
    if (bursts.size() == 2) begin
      checkValue("b2b first data", bursts[0].data, 32'h010F00);
      checkValue("b2b first length", 32'(bursts[0].len), 32'(EN_HOLD));
      checkValue("b2b second data", bursts[1].data, 32'h0400AA);
      checkValue("b2b second length", 32'(bursts[1].len), 32'(EN_HOLD));
    end
    checkValue("b2b o_data", 32'(bus.o_data), 32'h0400AA);
    bursts.delete();

    // Reset in the middle of a frame: nothing partial may come out.
    applyStimulus(12, 32'h05F, 1'b0, misoBits);
    resetN     = 1'b0;
    bus.i_cs_n = 1'b1;
    bus.i_sck  = 1'b0;
    bus.i_mosi = 1'b0;
    repeat (3) tick();
    checkValue("mid-reset o_data", 32'(bus.o_data), 32'd0);
    checkValue("mid-reset o_busy", 32'(bus.o_busy), 32'd0);
    resetN = 1'b1;
    repeat (10) tick();
    checkValue("post-reset bursts", 32'(bursts.size()), 32'd0);
    checkValue("post-reset o_frame_err", 32'(bus.o_frame_err), 32'd0);
    applyStimulus(24, 32'h060080, 1'b1, misoBits);
    checkOutput("frame after reset", 1'b1, 32'h060080, 1'b0);

    // Stray SCK edges with CS high must leave no trace.
    for (int i = 0; i < 10; i++) begin
      bus.i_mosi = i[0];
      bus.i_sck  = 1'b1;
      repeat (4) tick();
      bus.i_sck  = 1'b0;
      repeat (4) tick();
    end
    checkValue("stray sck o_busy", 32'(bus.o_busy), 32'd0);
    checkValue("stray sck bursts", 32'(bursts.size()), 32'd0);
    checkValue("stray sck o_data", 32'(bus.o_data), 32'h060080);
    applyStimulus(24, 32'h0AC3C3, 1'b1, misoBits);
    checkOutput("frame after stray sck", 1'b1, 32'h0AC3C3, 1'b0);

`ifdef SPI_MISO_ECHO_EN
    applyStimulus(24, 32'h07ABCD, 1'b1, misoBits);
    checkOutput("echo source frame", 1'b1, 32'h07ABCD, 1'b0);
    applyStimulus(24, 32'h000000, 1'b1, misoBits);
    checkValue("echo miso bits", misoBits, 32'h07ABCD);
    checkOutput("echo carrier frame", 1'b1, 32'h000000, 1'b0);
`else
    applyStimulus(24, 32'h07ABCD, 1'b1, misoBits);
    checkValue("miso tied low", misoBits, 32'd0);
    checkOutput("frame 07ABCD", 1'b1, 32'h07ABCD, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
